// File: rtl/ram2r1w_responder_if.sv
// Kernel-facing bus of the 2-read/1-write RAM responder: kernel ports, debug
// preload/dump ports, and status/counter outputs.
interface ram2r1w_responder_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
);
  logic [ADDR_WIDTH-1:0] raddr0;
  logic [WIDTH-1:0]      rdata0;
  logic [ADDR_WIDTH-1:0] raddr1;
  logic [WIDTH-1:0]      rdata1;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [WIDTH-1:0]      wdata;
  logic                  wen;
  logic [ADDR_WIDTH-1:0] debug_write_addr;
  logic [WIDTH-1:0]      debug_write_data;
  logic                  debug_write_en;
  logic [ADDR_WIDTH-1:0] debug_addr;
  logic [WIDTH-1:0]      debug_data;
  logic                  ready;
  logic                  dbg_wr_drop;
  logic [CNT_WIDTH-1:0]  wr_count;
  logic [CNT_WIDTH-1:0]  rd_count;

  modport master (
    output raddr0, raddr1, waddr, wdata, wen,
    output debug_write_addr, debug_write_data, debug_write_en, debug_addr,
    input  rdata0, rdata1, debug_data, ready, dbg_wr_drop, wr_count, rd_count
  );

  modport slave (
    input  raddr0, raddr1, waddr, wdata, wen,
    input  debug_write_addr, debug_write_data, debug_write_en, debug_addr,
    output rdata0, rdata1, debug_data, ready, dbg_wr_drop, wr_count, rd_count
  );
endinterface

// File: rtl/ram2r1w_responder.sv
// DEPTH x WIDTH RAM with two registered read-first read ports, one kernel write
// port, debug preload/dump ports, an optional post-reset zero-fill and counters.
module ram2r1w_responder #(
  parameter int WIDTH          = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int CLEAR_ON_RESET = 1,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                clk,
  input  logic                rst,
  ram2r1w_responder_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam state_e                 RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
  localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR   = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE    = ADDR_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]   CNT_MAX     = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]   CNT_TWO     = CNT_WIDTH'(2);

  logic [WIDTH-1:0]      mem_q [DEPTH];

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0]      rdata0_q, rdata0_d;
  logic [WIDTH-1:0]      rdata1_q, rdata1_d;
  logic [WIDTH-1:0]      debug_data_q, debug_data_d;
  logic                  drop_q, drop_d;
  logic [CNT_WIDTH-1:0]  wr_count_q, wr_count_d;
  logic [CNT_WIDTH-1:0]  rd_count_q, rd_count_d;

  logic                  mem_we_s;
  logic [ADDR_WIDTH-1:0] mem_waddr_s;
  logic [WIDTH-1:0]      mem_wdata_s;
  logic                  commit_s;

  // Next-state, single array write port arbitration, read capture and counters.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    rdata0_d     = '0;
    rdata1_d     = '0;
    debug_data_d = '0;
    drop_d       = 1'b0;
    rd_count_d   = rd_count_q;
    mem_we_s     = 1'b0;
    mem_waddr_s  = bus.waddr;
    mem_wdata_s  = bus.wdata;
    commit_s     = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        mem_we_s    = 1'b1;
        mem_waddr_s = ptr_q;
        mem_wdata_s = '0;
        ptr_d       = ptr_q + ADDR_ONE;
        drop_d      = bus.debug_write_en;
        if (ptr_q == LAST_ADDR) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_RUN: begin
        // Array reads see the pre-edge contents, which gives read-first behaviour.
        rdata0_d     = mem_q[bus.raddr0];
        rdata1_d     = mem_q[bus.raddr1];
        debug_data_d = mem_q[bus.debug_addr];
        if (bus.wen) begin
          mem_we_s = 1'b1;
          commit_s = 1'b1;
          drop_d   = bus.debug_write_en;
        end else if (bus.debug_write_en) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = bus.debug_write_addr;
          mem_wdata_s = bus.debug_write_data;
          commit_s    = 1'b1;
        end else begin
          mem_we_s = 1'b0;
          commit_s = 1'b0;
        end
        if (rd_count_q >= (CNT_MAX - CNT_ONE)) begin
          rd_count_d = CNT_MAX;
        end else begin
          rd_count_d = rd_count_q + CNT_TWO;
        end
      end
      default: begin
        state_d = RESET_STATE;
        ptr_d   = '0;
      end
    endcase

    if (commit_s && (wr_count_q != CNT_MAX)) begin
      wr_count_d = wr_count_q + CNT_ONE;
    end else begin
      wr_count_d = wr_count_q;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RESET_STATE;
      ptr_q        <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      debug_data_q <= '0;
      drop_q       <= 1'b0;
      wr_count_q   <= '0;
      rd_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      debug_data_q <= debug_data_d;
      drop_q       <= drop_d;
      wr_count_q   <= wr_count_d;
      rd_count_q   <= rd_count_d;
    end
  end

  // Storage array; deliberately not reset, the clear sequencer zeroes it instead.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  assign bus.rdata0      = rdata0_q;
  assign bus.rdata1      = rdata1_q;
  assign bus.debug_data  = debug_data_q;
  assign bus.ready       = (state_q == ST_RUN);
  assign bus.dbg_wr_drop = drop_q;
  assign bus.wr_count    = wr_count_q;
  assign bus.rd_count    = rd_count_q;
endmodule

// File: tb/tb_ram2r1w_responder.sv
// Scoreboard bench for ram2r1w_responder: a behavioural array model queues the
// expected outputs for each cycle and a negedge monitor compares them.
module tb_ram2r1w_responder;
  localparam int WIDTH        = 32;
  localparam int AW           = 5;
  localparam int CW           = 16;
  localparam int DEPTH        = 32;
  localparam int CLEAR_CYCLES = 32;
  localparam int CNT_SAT      = 65535;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram2r1w_responder_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  ram2r1w_responder #(
    .WIDTH(WIDTH), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(1), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_mem [DEPTH];
  int          since_rel;
  int          ref_wr;
  int          ref_rd;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kind_name(int k);
    case (k)
      0: return "rdata0";
      1: return "rdata1";
      2: return "debug_data";
      3: return "ready";
      4: return "dbg_wr_drop";
      5: return "wr_count";
      6: return "rd_count";
      default: return "unknown";
    endcase
  endfunction

  function automatic logic [31:0] actual(int k);
    case (k)
      0: return bus.rdata0;
      1: return bus.rdata1;
      2: return bus.debug_data;
      3: return {31'd0, bus.ready};
      4: return {31'd0, bus.dbg_wr_drop};
      5: return {16'd0, bus.wr_count};
      6: return {16'd0, bus.rd_count};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic void push(int k, logic [31:0] v);
    exp_t e;
    e.due  = cyc + 1;
    e.kind = k;
    e.exp  = v;
    sb.push_back(e);
  endfunction

  // Monitor: compare every expectation that falls due on this cycle.
  initial begin
    exp_t        e;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        checks++;
        a = actual(e.kind);
        if (e.due != cyc) begin
          errors++;
          $display("FAIL stale_%s: due cycle %0d checked at %0d", kind_name(e.kind), e.due, cyc);
        end else if (a !== e.exp) begin
          errors++;
          $display("FAIL %s at cycle %0d: got %0h expected %0h", kind_name(e.kind), cyc, a, e.exp);
        end
      end
    end
  end

  task automatic idle();
    bus.wen            = 1'b0;
    bus.debug_write_en = 1'b0;
  endtask

  // One clock of stimulus: expected outputs come from the array model.
  task automatic tick();
    bit run;
    bit drop;
    run  = (since_rel >= CLEAR_CYCLES);
    drop = bus.debug_write_en && (!run || bus.wen);
    if (run) begin
      push(0, ref_mem[bus.raddr0]);
      push(1, ref_mem[bus.raddr1]);
      push(2, ref_mem[bus.debug_addr]);
      if (bus.wen) begin
        ref_mem[bus.waddr] = bus.wdata;
        if (ref_wr < CNT_SAT) ref_wr++;
      end else if (bus.debug_write_en) begin
        ref_mem[bus.debug_write_addr] = bus.debug_write_data;
        if (ref_wr < CNT_SAT) ref_wr++;
      end
      ref_rd = (ref_rd + 2 > CNT_SAT) ? CNT_SAT : ref_rd + 2;
    end
    if (since_rel < CLEAR_CYCLES) since_rel++;
    push(3, (since_rel >= CLEAR_CYCLES) ? 32'd1 : 32'd0);
    push(4, drop ? 32'd1 : 32'd0);
    push(5, ref_wr);
    push(6, ref_rd);
    @(posedge clk);
    #1;
  endtask

  // Assert reset mid-cycle, expect all outputs at reset values, release after one edge.
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    idle();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
    since_rel = 0;
    ref_wr    = 0;
    ref_rd    = 0;
    for (int k = 0; k < 7; k++) push(k, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic dbg_write(int a, logic [31:0] d);
    bus.debug_write_en   = 1'b1;
    bus.debug_write_addr = AW'(a);
    bus.debug_write_data = d;
    tick();
    bus.debug_write_en   = 1'b0;
  endtask

  task automatic sweep_reads();
    for (int i = 0; i < DEPTH; i++) begin
      bus.raddr0     = AW'(i);
      bus.raddr1     = AW'(DEPTH - 1 - i);
      bus.debug_addr = AW'(i);
      tick();
    end
  endtask

  task automatic preload();
    for (int i = 0; i < DEPTH; i++) dbg_write(i, 32'(i + 1));
  endtask

  initial begin
    logic [31:0] k_val;
    bus.raddr0 = '0; bus.raddr1 = '0; bus.debug_addr = '0;
    bus.waddr = '0; bus.wdata = '0; bus.debug_write_addr = '0; bus.debug_write_data = '0;
    idle();

    // 1: clear after reset, then everything reads zero
    do_reset();
    for (int i = 0; i < CLEAR_CYCLES; i++) begin
      if (i == 5) bus.debug_write_en = 1'b1;
      else        bus.debug_write_en = 1'b0;
      tick();
    end
    sweep_reads();

    // 2: preload i+1, read back address 10 on port 0 and debug port
    preload();
    bus.raddr0 = 5'd10; bus.debug_addr = 5'd10;
    tick();

    // 3: read-during-write returns old value, new value next cycle
    dbg_write(4, 32'd5);
    bus.wen = 1'b1; bus.waddr = 5'd4; bus.wdata = 32'd99; bus.raddr1 = 5'd4;
    tick();
    idle();
    tick();

    // 4: kernel/debug write collision
    bus.wen = 1'b1; bus.waddr = 5'd3; bus.wdata = 32'd7;
    bus.debug_write_en = 1'b1; bus.debug_write_addr = 5'd8; bus.debug_write_data = 32'd42;
    tick();
    idle();
    bus.raddr0 = 5'd3; bus.raddr1 = 5'd8;
    tick();
    tick();

    // 5: reset during run, then again at clear cycle 12; full clear must follow
    do_reset();
    for (int i = 0; i < 12; i++) tick();
    do_reset();
    for (int i = 0; i < CLEAR_CYCLES; i++) tick();
    sweep_reads();

    // 6: kernel-style array[10] <= array[0] + 4 + 6
    preload();
    bus.raddr0 = 5'd0;
    tick();
    k_val = bus.rdata0 + 32'd4 + 32'd6;
    bus.wen = 1'b1; bus.waddr = 5'd10; bus.wdata = k_val;
    tick();
    idle();
    bus.debug_addr = 5'd10;
    tick();
    tick();

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      bus.raddr0           = AW'($urandom_range(DEPTH - 1));
      bus.raddr1           = AW'($urandom_range(DEPTH - 1));
      bus.debug_addr       = AW'($urandom_range(DEPTH - 1));
      bus.wen              = ($urandom_range(2) == 0);
      bus.waddr            = AW'($urandom_range(DEPTH - 1));
      bus.wdata            = $urandom;
      bus.debug_write_en   = ($urandom_range(2) == 0);
      bus.debug_write_addr = AW'($urandom_range(DEPTH - 1));
      bus.debug_write_data = $urandom;
      tick();
    end
    idle();
    tick();

    for (int i = 0; i < 4 && sb.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ram2r1w_responder.md
Name: ram2r1w_responder

Overview:
Memory-side responder for generated HLS kernels: a DEPTH x WIDTH RAM that serves two read ports and one write port driven by the kernel (raddr_*/rdata_*, waddr/wdata/wen).
A debug write port preloads test data and a debug read port dumps results, so benches can seed and check memory around a kernel run.
An optional post-reset clear sequencer zeroes the array before the kernel may access it.
Write-commit and read-service counters support bench-level checks.

Parameters:
WIDTH, 32, data word width
ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH = 32 entries, so no out-of-range addresses exist
CLEAR_ON_RESET, 1, 1 = run the zero-fill sequence after reset release; 0 = array contents undefined, ready immediately
CNT_WIDTH, 16, width of the access counters

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  asynchronous, active-low reset
raddr0  in  ADDR_WIDTH  read port 0 address, sampled every cycle
rdata0  out  WIDTH  read port 0 data, registered
raddr1  in  ADDR_WIDTH  read port 1 address
rdata1  out  WIDTH  read port 1 data, registered
waddr  in  ADDR_WIDTH  kernel write address
wdata  in  WIDTH  kernel write data
wen  in  1  kernel write enable
debug_write_addr  in  ADDR_WIDTH  preload address
debug_write_data  in  WIDTH  preload data
debug_write_en  in  1  preload enable
debug_addr  in  ADDR_WIDTH  dump address
debug_data  out  WIDTH  dump data, registered
ready  out  1  high when the array is accessible (RUN state)
dbg_wr_drop  out  1  one-cycle pulse: a debug write was dropped
wr_count  out  CNT_WIDTH  committed writes, kernel and debug
rd_count  out  CNT_WIDTH  read-port samples taken while ready

Behaviour:
- Reset (rst=0, async): rdata0, rdata1, debug_data = 0; dbg_wr_drop = 0; wr_count, rd_count = 0; clear pointer = 0; state = CLEAR if CLEAR_ON_RESET, else RUN. Array is not reset directly.
- CLEAR state:
  - Each cycle writes 0 to array[ptr], then ptr++.
  - After the write to DEPTH-1, go to RUN; ready rises the following cycle. Total: 32 cycles after reset release.
  - ready = 0 throughout.
  - wen and debug_write_en are ignored. A debug write here pulses dbg_wr_drop.
  - Reads still register but return undefined or zeroed data; rd_count does not count them.
  - Clear writes do not increment wr_count.
- RUN state:
  - Reads: rdataN <= array[raddrN] at each posedge, 1-cycle latency. Both ports may hit the same address.
  - Read-during-write to the same address returns the OLD value (read-first); the new value is visible the next cycle.
  - debug_data <= array[debug_addr], 1-cycle latency, same read-first rule.
  - Kernel write: if wen, array[waddr] <= wdata.
  - Debug write: if debug_write_en and !wen, array[debug_write_addr] <= debug_write_data.
  - If debug_write_en and wen are both high, the debug write is dropped (any address) and dbg_wr_drop = 1 for that cycle. Kernel writes always win.
  - wr_count += 1 per committed write, at most 1 per cycle; saturates at all-ones.
  - rd_count += 2 per cycle while ready; saturates.
- Reset asserted mid-CLEAR or mid-RUN: immediately returns to reset values. A clear restarts from address 0 on release.
- No back-pressure: the kernel must not issue accesses until ready = 1.

Test Plan:
1. Reset release with CLEAR_ON_RESET=1 -> ready = 0 for 32 cycles, then 1. Reading addresses 0..31 on both ports returns 0; wr_count = 0.
2. Preload via debug port: addr i <- i+1 for i = 0..31. Then raddr0 = 10 -> rdata0 = 11 one cycle later; debug_addr = 10 -> debug_data = 11; wr_count = 32.
3. Read-during-write: array[4] = 5; wen = 1, waddr = 4, wdata = 99, raddr1 = 4 in the same cycle -> rdata1 = 5, and the next-cycle read gives 99.
4. Collision: wen = 1 (addr 3, data 7) and debug_write_en = 1 (addr 8, data 42) in the same cycle -> array[3] = 7, array[8] unchanged, dbg_wr_drop pulses for 1 cycle, wr_count += 1.
5. Reset pulse at CLEAR cycle 12 -> outputs return to 0. After release, ready rises exactly 32 cycles later; previously preloaded data reads back as 0.
6. Kernel-style run: preload 1..32, then perform array[10] <= array[0] + 4 + 6 using port 0 and wen -> debug_data at addr 10 reads 11.
